drive_ctrl: RTL

Second-generation cart drive controller: decodes IR remote commands into motor speed, direction and steering set-points, with slew-rate-limited speed ramping, safe direction reversal and a timed back-off/turn obstacle-avoidance sequence. Sits between the IR decoder (ready/ack handshake) and the motor/servo PWM generators, and replaces the derived-clock controller with a single-clock design driven by an internal tick enable. All widths, step sizes and avoidance timings are parameters.

---
 rtl/drive_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/drive_ctrl.sv
// Cart drive controller: IR command decode to motor/servo set-points with slew-limited speed ramp and obstacle back-off/turn.
// Latency: command takes effect and is acked one cycle after the consuming edge; motor_dc then moves at most RAMP_STEP per tick.
// Backpressure: one command consumed per two cycles (ack blocks re-consume); the decoder must drop ir_ready on ack.
//
// Ports: clk/rst (async active-low); ir_ready/command/ack = IR decoder handshake;
//        can_move_fwd = obstacle sensor (0 = blocked); ctl_valid/running/direction/motor_dc/
//        servo_dc/avoid_active/fsm_state = set-points and status for the PWM stage.
module drive_ctrl #(
    parameter int CLK_HZ       = 25000000,
    parameter int TICK_HZ      = 256,
    parameter int DC_W         = 8,
    parameter int SERVO_MIN    = 0,
    parameter int SERVO_MAX    = 255,
    parameter int SERVO_CENTER = 155,
    parameter int SERVO_STEP   = 32,
    parameter int SERVO_AVOID  = 50,
    parameter int MOTOR_MAX    = 255,
    parameter int MOTOR_STEP   = 32,
    parameter int RAMP_STEP    = 4,
    parameter int AVOID_DC     = 128,
    parameter int BACK_TICKS   = 250,
    parameter int TURN_TICKS   = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_ready,
    input  logic [31:0]     command,
    input  logic            can_move_fwd,
    output logic            ack,
    output logic            ctl_valid,
    output logic            running,
    output logic            direction,
    output logic [DC_W-1:0] motor_dc,
    output logic [DC_W-1:0] servo_dc,
    output logic            avoid_active,
    output logic [1:0]      fsm_state
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AV_MAX   = (BACK_TICKS > TURN_TICKS) ? BACK_TICKS : TURN_TICKS;
    localparam int AW       = $clog2(AV_MAX + 1);

    typedef logic [DC_W:0] wide_t;
    localparam wide_t W_SMIN  = wide_t'(SERVO_MIN);
    localparam wide_t W_SMAX  = wide_t'(SERVO_MAX);
    localparam wide_t W_SSTEP = wide_t'(SERVO_STEP);
    localparam wide_t W_MMAX  = wide_t'(MOTOR_MAX);
    localparam wide_t W_MSTEP = wide_t'(MOTOR_STEP);
    localparam wide_t W_RAMP  = wide_t'(RAMP_STEP);

    localparam logic [DC_W-1:0] SMIN    = DC_W'(SERVO_MIN);
    localparam logic [DC_W-1:0] SMAX    = DC_W'(SERVO_MAX);
    localparam logic [DC_W-1:0] SCENTER = DC_W'(SERVO_CENTER);
    localparam logic [DC_W-1:0] SSTEP   = DC_W'(SERVO_STEP);
    localparam logic [DC_W-1:0] SAVOID  = DC_W'(SERVO_AVOID);
    localparam logic [DC_W-1:0] MMAX    = DC_W'(MOTOR_MAX);
    localparam logic [DC_W-1:0] MSTEP   = DC_W'(MOTOR_STEP);
    localparam logic [DC_W-1:0] RSTEP   = DC_W'(RAMP_STEP);
    localparam logic [DC_W-1:0] ADC     = DC_W'(AVOID_DC);

    localparam logic [31:0] CODE_SRC    = 32'hFE010707;
    localparam logic [31:0] CODE_OFF    = 32'hFB040707;
    localparam logic [31:0] CODE_FWD    = 32'hED120707;
    localparam logic [31:0] CODE_REV    = 32'hEF100707;
    localparam logic [31:0] CODE_LEFT   = 32'h9A650707;
    localparam logic [31:0] CODE_RIGHT  = 32'h9D620707;
    localparam logic [31:0] CODE_UP     = 32'h9F600707;
    localparam logic [31:0] CODE_DOWN   = 32'h9E610707;
    localparam logic [31:0] CODE_STOP   = 32'h86790707;
    localparam logic [31:0] CODE_CENTER = 32'h97680707;

    typedef enum logic [1:0] {S_OFF = 2'd0, S_RUN = 2'd1, S_BACK = 2'd2, S_TURN = 2'd3} state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [AW-1:0]   avoid_cnt;
    logic [DC_W-1:0] target;
    logic            pending_dir;

    logic            consume, tick;
    wide_t           s_sum, t_sum, m_sum;
    logic [DC_W-1:0] servo_inc, servo_dec, tgt_inc, tgt_dec, ramp_motor;
    logic            ramp_dir;

    assign consume      = ir_ready & ~ack;
    assign tick         = (tick_cnt == TW'(TICK_DIV - 1));
    assign running      = (state != S_OFF);
    assign avoid_active = (state == S_BACK) || (state == S_TURN);
    assign fsm_state    = state;

    // Saturating set-point arithmetic and the per-tick ramp step, one bit wider than DC_W.
    always_comb begin
        s_sum     = {1'b0, servo_dc} + W_SSTEP;
        servo_inc = (s_sum > W_SMAX) ? SMAX : s_sum[DC_W-1:0];
        servo_dec = ({1'b0, servo_dc} < (W_SMIN + W_SSTEP)) ? SMIN : (servo_dc - SSTEP);
        t_sum     = {1'b0, target} + W_MSTEP;
        tgt_inc   = (t_sum > W_MMAX) ? MMAX : t_sum[DC_W-1:0];
        tgt_dec   = (target < MSTEP) ? '0 : (target - MSTEP);
        m_sum      = {1'b0, motor_dc} + W_RAMP;
        ramp_motor = motor_dc;
        ramp_dir   = direction;
        if (pending_dir != direction) begin
            // Reversal: spin down first, swap direction only on a tick that finds the motor stopped.
            if (motor_dc == '0)
                ramp_dir = pending_dir;
            else
                ramp_motor = (motor_dc < RSTEP) ? '0 : (motor_dc - RSTEP);
        end else if (motor_dc < target) begin
            ramp_motor = (m_sum > {1'b0, target}) ? target : m_sum[DC_W-1:0];
        end else if (motor_dc > target) begin
            ramp_motor = (({1'b0, motor_dc} - {1'b0, target}) > W_RAMP) ? (motor_dc - RSTEP) : target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_OFF;
            ack         <= 1'b0;
            ctl_valid   <= 1'b0;
            direction   <= 1'b1;
            pending_dir <= 1'b1;
            motor_dc    <= '0;
            servo_dc    <= SCENTER;
            target      <= '0;
            tick_cnt    <= '0;
            avoid_cnt   <= '0;
        end else begin
            ack       <= consume;
            ctl_valid <= 1'b1;
            tick_cnt  <= tick ? '0 : (tick_cnt + TW'(1));

            if (consume && command == CODE_OFF) begin
                // Power-off wins over everything, including an in-progress avoid sequence.
                state       <= S_OFF;
                motor_dc    <= '0;
                target      <= '0;
                servo_dc    <= SCENTER;
                direction   <= 1'b1;
                pending_dir <= 1'b1;
                avoid_cnt   <= '0;
            end else begin
                unique case (state)
                    S_OFF: begin
                        if (consume && command == CODE_SRC)
                            state <= S_RUN;
                    end
                    S_RUN: begin
                        if (direction && !can_move_fwd) begin
                            state       <= S_BACK;
                            motor_dc    <= '0;
                            direction   <= 1'b0;
                            pending_dir <= 1'b0;
                            target      <= ADC;
                            servo_dc    <= SAVOID;
                            avoid_cnt   <= '0;
                        end else begin
                            if (consume) begin
                                case (command)
                                    CODE_FWD:    pending_dir <= 1'b1;
                                    CODE_REV:    pending_dir <= 1'b0;
                                    CODE_LEFT:   servo_dc    <= servo_inc;
                                    CODE_RIGHT:  servo_dc    <= servo_dec;
                                    CODE_UP:     if (!(direction && !can_move_fwd)) target <= tgt_inc;
                                    CODE_DOWN:   target      <= tgt_dec;
                                    CODE_STOP:   target      <= '0;
                                    CODE_CENTER: servo_dc    <= SCENTER;
                                    default:     ;
                                endcase
                            end
                            if (tick) begin
                                motor_dc  <= ramp_motor;
                                direction <= ramp_dir;
                            end
                        end
                    end
                    S_BACK: begin
                        if (tick) begin
                            if (avoid_cnt == AW'(BACK_TICKS - 1)) begin
                                state       <= S_TURN;
                                motor_dc    <= '0;
                                direction   <= 1'b1;
                                pending_dir <= 1'b1;
                                target      <= ADC;
                                avoid_cnt   <= '0;
                            end else begin
                                avoid_cnt <= avoid_cnt + AW'(1);
                                motor_dc  <= ramp_motor;
                                direction <= ramp_dir;
                            end
                        end
                    end
                    S_TURN: begin
                        if (!can_move_fwd) begin
                            state       <= S_BACK;
                            motor_dc    <= '0;
                            direction   <= 1'b0;
                            pending_dir <= 1'b0;
                            target      <= ADC;
                            servo_dc    <= SAVOID;
                            avoid_cnt   <= '0;
                        end else if (tick) begin
                            if (avoid_cnt == AW'(TURN_TICKS - 1)) begin
                                state       <= S_RUN;
                                motor_dc    <= '0;
                                target      <= '0;
                                servo_dc    <= SCENTER;
                                direction   <= 1'b1;
                                pending_dir <= 1'b1;
                                avoid_cnt   <= '0;
                            end else begin
                                avoid_cnt <= avoid_cnt + AW'(1);
                                motor_dc  <= ramp_motor;
                                direction <= ramp_dir;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
